// File: rtl/config_loader.sv
// Configuration bitstream loader: shifts NUM_WORDS words into config_out,
// then compares a trailing checksum word against the running XOR of those words.
module config_loader #(
  parameter int unsigned CONFIG_WIDTH = 34688,
  parameter int unsigned WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  output logic                    config_error,
  output logic                    busy
);

  localparam int unsigned NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   csum_q, csum_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic [CONFIG_WIDTH+WORD_WIDTH-1:0] shift_ext;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      cfg_q   <= cfg_d;
    end
  end

  // Concatenate-then-slice keeps the shift legal even when NUM_WORDS == 1.
  assign shift_ext = {data_in, cfg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    cfg_d   = cfg_q;
    if (start) begin
      // Restart wins over any coincident transfer; that word is dropped.
      state_d = LOAD;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        LOAD: if (data_valid) begin
          cfg_d  = shift_ext[CONFIG_WIDTH+WORD_WIDTH-1:WORD_WIDTH];
          csum_d = csum_q ^ data_in;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = CHECK;
        end
        CHECK: if (data_valid) begin
          state_d = (data_in == csum_q) ? DONE : ERROR;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q == LOAD) || (state_q == CHECK);
  assign data_ready   = busy;
  assign config_done  = (state_q == DONE);
  assign config_error = (state_q == ERROR);
  assign config_out   = cfg_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader at CONFIG_WIDTH=64, WORD_WIDTH=16.
module tb_config_loader;

  localparam int CW = 64;
  localparam int WW = 16;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [CW-1:0] config_out;
  logic          config_done;
  logic          config_error;
  logic          busy;

  int checks = 0;
  int errors = 0;

  config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock(clock), .nreset(nreset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .config_out(config_out),
    .config_done(config_done), .config_error(config_error), .busy(busy)
  );

  always #5 clock = ~clock;

  localparam logic [CW-1:0] GOOD = 64'h8888_4444_2222_1111;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [WW-1:0] w);
    data_valid = 1'b1; data_in = w; step(); data_valid = 1'b0; data_in = '0;
  endtask

  task automatic send_stream(input logic [WW-1:0] csum);
    send(16'h1111); send(16'h2222); send(16'h4444); send(16'h8888); send(csum);
  endtask

  initial begin
    logic [WW-1:0] words [5];
    logic [CW-1:0] prev;
    int idx, cyc;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h4444;
    words[3] = 16'h8888; words[4] = 16'hFFFF;

    // Reset state
    #2;
    chk("rst_cfg", config_out, '0);
    chk("rst_done", CW'(config_done), '0);
    chk("rst_err", CW'(config_error), '0);
    chk("rst_busy", CW'(busy), '0);
    chk("rst_ready", CW'(data_ready), '0);
    step(); nreset = 1'b1;

    // Release of reset starts nothing; valid data ignored in IDLE
    data_valid = 1'b1; data_in = 16'h5A5A;
    repeat (3) step();
    chk("idle_ready", CW'(data_ready), '0);
    chk("idle_cfg", config_out, '0);
    data_valid = 1'b0;

    // Clean load
    pulse_start();
    chk("load_busy", CW'(busy), 1);
    chk("load_ready", CW'(data_ready), 1);
    send(16'h1111); send(16'h2222); send(16'h4444); send(16'h8888);
    chk("check_cfg", config_out, GOOD);
    chk("check_busy", CW'(busy), 1);
    chk("check_done0", CW'(config_done), 0);
    send(16'hFFFF);
    chk("clean_done", CW'(config_done), 1);
    chk("clean_err", CW'(config_error), 0);
    chk("clean_busy", CW'(busy), 0);
    chk("clean_cfg", config_out, GOOD);

    // Idle ignore in DONE
    data_valid = 1'b1; data_in = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("done_hold_cfg", config_out, GOOD);
      chk("done_hold_done", CW'(config_done), 1);
      chk("done_hold_ready", CW'(data_ready), 0);
    end
    data_valid = 1'b0;

    // Bad checksum
    pulse_start();
    chk("restart_done0", CW'(config_done), 0);
    send_stream(16'hFFFE);
    chk("bad_err", CW'(config_error), 1);
    chk("bad_done", CW'(config_done), 0);
    chk("bad_cfg", config_out, GOOD);
    chk("bad_busy", CW'(busy), 0);

    // Backpressure with random gaps
    pulse_start();
    chk("bp_err_clr", CW'(config_error), 0);
    idx = 0; cyc = 0;
    while (idx < 5 && cyc < 200) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in = data_valid ? words[idx] : 16'h0BAD;
      prev = config_out;
      step();
      if (data_valid) idx++;
      else chk("bp_gap_hold", config_out, prev);
      cyc++;
    end
    data_valid = 1'b0;
    chk("bp_bound", CW'(idx), 5);
    chk("bp_done", CW'(config_done), 1);
    chk("bp_cfg", config_out, GOOD);

    // Restart mid-load, second start coincides with a valid word
    pulse_start();
    send(16'hAAAA); send(16'hBBBB);
    start = 1'b1; data_valid = 1'b1; data_in = 16'hCCCC;
    step();
    start = 1'b0; data_valid = 1'b0;
    chk("rs_drop_cfg", config_out, 64'hBBBB_AAAA_8888_4444);
    chk("rs_busy", CW'(busy), 1);
    send(16'h1111); send(16'h2222); send(16'h4444);
    chk("rs_still_load", CW'(config_done), 0);
    send(16'h8888);
    chk("rs_check_cfg", config_out, GOOD);
    send(16'hFFFF);
    chk("rs_done", CW'(config_done), 1);

    // Reset mid-load
    pulse_start();
    send(16'h1234); send(16'h5678); send(16'h9ABC);
    #2 nreset = 1'b0;
    #1;
    chk("arst_cfg", config_out, '0);
    chk("arst_busy", CW'(busy), 0);
    chk("arst_ready", CW'(data_ready), 0);
    chk("arst_done", CW'(config_done), 0);
    chk("arst_err", CW'(config_error), 0);
    step(); nreset = 1'b1;
    data_valid = 1'b1; data_in = 16'h7777;
    repeat (4) step();
    chk("post_rst_ready", CW'(data_ready), 0);
    chk("post_rst_busy", CW'(busy), 0);
    chk("post_rst_cfg", config_out, '0);
    data_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
